// File: rtl/fifo_stream_checker.sv
// Read-side traffic engine for simple_fifo: drains the FIFO and checks each word
// against an incrementing pattern that starts at SEED; results feed ILA/VIO probes.
module fifo_stream_checker #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED = '0,
    parameter int              CNT_W = 32,
    parameter int              ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             stop_on_err,
    input  logic [3:0]       rd_gap,
    input  logic             empty,
    input  logic [WIDTH-1:0] data_out,
    output logic             rd,
    output logic             busy,
    output logic [CNT_W-1:0] check_count,
    output logic [ERR_W-1:0] err_count,
    output logic             err_flag,
    output logic [WIDTH-1:0] first_err_got,
    output logic [WIDTH-1:0] first_err_exp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       gap_q, gap_d;
    logic             rd_q, rd_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             flag_q, flag_d;
    logic [WIDTH-1:0] got_cap_q, got_cap_d;
    logic [WIDTH-1:0] exp_cap_q, exp_cap_d;
    logic             mismatch;

    // rd_q marks the cycle in which the FIFO presents the word read one cycle earlier.
    assign rd   = (state_q == ST_RUN) && !empty && (gap_q == 4'd0);
    assign busy = (state_q == ST_RUN) || rd_q;

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        rd_d      = rd;
        exp_d     = exp_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        flag_d    = flag_q;
        got_cap_d = got_cap_q;
        exp_cap_d = exp_cap_q;
        mismatch  = rd_q && (data_out != exp_q);

        if (rd) begin
            gap_d = rd_gap;
        end else if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end

        unique case (state_q)
            ST_IDLE: if (enable) state_d = ST_RUN;
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (mismatch && stop_on_err) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        // The in-flight word is checked regardless of state, so it still counts
        // after enable drops or after the halting mismatch.
        if (rd_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (mismatch) begin
                if (err_q != '1) err_d = err_q + ERR_W'(1);
                if (!flag_q) begin
                    flag_d    = 1'b1;
                    got_cap_d = data_out;
                    exp_cap_d = exp_q;
                end
                exp_d = data_out + WIDTH'(1);
            end else begin
                exp_d = exp_q + WIDTH'(1);
            end
        end

        if (clear) begin
            state_d   = ST_IDLE;
            gap_d     = 4'd0;
            rd_d      = 1'b0;
            exp_d     = SEED;
            cnt_d     = '0;
            err_d     = '0;
            flag_d    = 1'b0;
            got_cap_d = '0;
            exp_cap_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gap_q     <= 4'd0;
            rd_q      <= 1'b0;
            exp_q     <= SEED;
            cnt_q     <= '0;
            err_q     <= '0;
            flag_q    <= 1'b0;
            got_cap_q <= '0;
            exp_cap_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            rd_q      <= rd_d;
            exp_q     <= exp_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            flag_q    <= flag_d;
            got_cap_q <= got_cap_d;
            exp_cap_q <= exp_cap_d;
        end
    end

    assign check_count   = cnt_q;
    assign err_count     = err_q;
    assign err_flag      = flag_q;
    assign first_err_got = got_cap_q;
    assign first_err_exp = exp_cap_q;

endmodule

// File: tb/tb_fifo_stream_checker.sv
// Bench for fifo_stream_checker: a queue-based FIFO feeds two instances (SEED=0 with wide
// counters, SEED=0xFE with narrow counters) and results are compared to a stream model.
module tb_fifo_stream_checker;

    logic       clk = 1'b0;
    logic       rst_n, enable, clear, stop_on_err, empty;
    logic [3:0] rd_gap;
    logic [7:0] data_out;

    logic        rd, busy, err_flag;
    logic [31:0] check_count;
    logic [15:0] err_count;
    logic [7:0]  first_err_got, first_err_exp;

    logic       rd_b, busy_b, ef_b;
    logic [3:0] cc_b;
    logic [1:0] ec_b;
    logic [7:0] fg_b, fe_b;

    logic [7:0] fifo_q[$];
    logic [7:0] pend_q[$];
    logic [7:0] w[$];
    int         rd_cyc[$];
    int         cyc, n_vec, n_err;
    bit         rd_s, trickle, rd_diff;

    always #5 clk = ~clk;

    fifo_stream_checker #(.WIDTH(8), .SEED(8'h00), .CNT_W(32), .ERR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .stop_on_err(stop_on_err),
        .rd_gap(rd_gap), .empty(empty), .data_out(data_out), .rd(rd), .busy(busy),
        .check_count(check_count), .err_count(err_count), .err_flag(err_flag),
        .first_err_got(first_err_got), .first_err_exp(first_err_exp)
    );

    fifo_stream_checker #(.WIDTH(8), .SEED(8'hFE), .CNT_W(4), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .stop_on_err(stop_on_err),
        .rd_gap(rd_gap), .empty(empty), .data_out(data_out), .rd(rd_b), .busy(busy_b),
        .check_count(cc_b), .err_count(ec_b), .err_flag(ef_b),
        .first_err_got(fg_b), .first_err_exp(fe_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; samples rd just before the edge, models the FIFO pop and
    // its one-cycle read latency, optionally trickles in a new word, returns at negedge.
    task automatic tick();
        #4;
        rd_s = rd;
        if (rd_b !== rd) rd_diff = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_s) begin
            if (fifo_q.size() == 0) begin
                check_eq("rd_on_empty", 1, 0);
            end else begin
                data_out = fifo_q.pop_front();
                rd_cyc.push_back(cyc);
            end
        end
        if (trickle && pend_q.size() > 0 && $urandom_range(0, 2) == 0)
            fifo_q.push_back(pend_q.pop_front());
        empty = (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    // Stream-level model: words are taken in order against an incrementing pattern.
    task automatic model(input logic [7:0] words[$], input logic [7:0] seed, input longint err_max,
                         output longint cc, output longint ec, output bit fl,
                         output logic [7:0] g, output logic [7:0] e);
        logic [7:0] nxt;
        nxt = seed; cc = 0; ec = 0; fl = 0; g = 0; e = 0;
        foreach (words[i]) begin
            cc++;
            if (words[i] == nxt) begin
                nxt = nxt + 8'd1;
            end else begin
                if (ec < err_max) ec++;
                if (!fl) begin
                    fl = 1'b1;
                    g  = words[i];
                    e  = nxt;
                end
                nxt = words[i] + 8'd1;
            end
        end
    endtask

    // Number of words the SEED=0 instance consumes before stopping.
    function automatic int n_checked(input logic [7:0] words[$], input int gap, input bit stop);
        int n;
        n = words.size();
        if (!stop) return n;
        for (int i = 0; i < n; i++)
            if (words[i] != 8'(i)) return (gap == 0 && i + 1 < n) ? i + 2 : i + 1;
        return n;
    endfunction

    task automatic run_stream(input logic [7:0] words[$], input int gap, input bit stop, input bit trk);
        int  t;
        bit  done;
        enable = 1'b0; rd_gap = 4'(gap); stop_on_err = stop; trickle = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        fifo_q.delete(); pend_q.delete(); rd_cyc.delete(); rd_diff = 1'b0;
        trickle = trk;
        if (trk) pend_q = words;
        else fifo_q = words;
        empty  = (fifo_q.size() == 0);
        enable = 1'b1;
        t = 0; done = 1'b0;
        while (!done && t < 3000) begin
            tick();
            t++;
            if (pend_q.size() == 0 && fifo_q.size() == 0) done = 1'b1;
            if (stop && t > 4 && !busy) done = 1'b1;
        end
        if (!done) check_eq("run_timeout", 0, 1);
        repeat (6) tick();
        enable = 1'b0;
        repeat (4) tick();
    endtask

    task automatic verify(input string tag, input logic [7:0] words[$], input int gap,
                          input bit stop, input bit trk);
        logic [7:0] chk[$];
        longint     cc, ec;
        bit         fl;
        logic [7:0] g, e;
        int         n, bad, d;
        n = n_checked(words, gap, stop);
        for (int i = 0; i < n; i++) chk.push_back(words[i]);
        model(chk, 8'h00, 65535, cc, ec, fl, g, e);
        check_eq({tag, "_rd_count"}, rd_cyc.size(), n);
        check_eq({tag, "_check_count"}, check_count, cc);
        check_eq({tag, "_err_count"}, err_count, ec);
        check_eq({tag, "_err_flag"}, err_flag, fl);
        check_eq({tag, "_first_got"}, first_err_got, g);
        check_eq({tag, "_first_exp"}, first_err_exp, e);
        check_eq({tag, "_busy"}, busy, 0);
        bad = 0;
        for (int i = 1; i < rd_cyc.size(); i++) begin
            d = rd_cyc[i] - rd_cyc[i-1];
            if (trk ? (d < gap + 1) : (d != gap + 1)) bad++;
        end
        check_eq({tag, "_rd_spacing"}, bad, 0);
        if (!stop) begin
            model(chk, 8'hFE, 3, cc, ec, fl, g, e);
            check_eq({tag, "_b_check_count"}, cc_b, cc % 16);
            check_eq({tag, "_b_err_count"}, ec_b, ec);
            check_eq({tag, "_b_err_flag"}, ef_b, fl);
            check_eq({tag, "_b_first_got"}, fg_b, g);
            check_eq({tag, "_b_first_exp"}, fe_b, e);
            check_eq({tag, "_b_rd_match"}, rd_diff, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t, gap, n;
        bit         stop, trk;
        logic [7:0] cur;
        int         r;

        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; stop_on_err = 1'b0; rd_gap = 4'd0;
        empty = 1'b1; data_out = 8'h00; cyc = 0; rd_s = 1'b0; trickle = 1'b0; rd_diff = 1'b0;
        n_vec = 0; n_err = 0;
        @(negedge clk);
        tick();
        tick();
        check_eq("rst_rd", rd, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_check_count", check_count, 0);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_err_flag", err_flag, 0);
        check_eq("rst_first_got", first_err_got, 0);
        check_eq("rst_first_exp", first_err_exp, 0);
        rst_n = 1'b1;
        tick();

        // 32 back-to-back words
        w.delete();
        for (int i = 0; i < 32; i++) w.push_back(8'(i));
        run_stream(w, 0, 0, 0);
        verify("b2b32", w, 0, 0, 0);
        check_eq("b2b32_span", rd_cyc[31] - rd_cyc[0], 31);

        // gap of 3: reads exactly 4 cycles apart
        w.delete();
        for (int i = 0; i < 8; i++) w.push_back(8'(i));
        run_stream(w, 3, 0, 0);
        verify("gap3", w, 3, 0, 0);

        // one dropped word costs exactly one error
        w = '{8'h00, 8'h01, 8'h03, 8'h04};
        run_stream(w, 0, 0, 0);
        verify("drop", w, 0, 0, 0);
        check_eq("drop_err_count", err_count, 1);
        check_eq("drop_first_got", first_err_got, 8'h03);
        check_eq("drop_first_exp", first_err_exp, 8'h02);
        check_eq("drop_check_count", check_count, 4);

        // halt on the first error, then clear
        w = '{8'h00, 8'h01, 8'h03, 8'h04, 8'h05};
        run_stream(w, 2, 1, 0);
        verify("halt", w, 2, 1, 0);
        check_eq("halt_check_count", check_count, 3);
        check_eq("halt_words_left", fifo_q.size(), 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check_eq("clr_check_count", check_count, 0);
        check_eq("clr_err_count", err_count, 0);
        check_eq("clr_err_flag", err_flag, 0);
        check_eq("clr_first_got", first_err_got, 0);
        check_eq("clr_first_exp", first_err_exp, 0);
        w = '{8'h00, 8'h01, 8'h02};
        run_stream(w, 1, 0, 0);
        verify("after_clr", w, 1, 0, 0);

        // wrap 0xFF -> 0x00 on the SEED=0xFE instance
        w = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        run_stream(w, 1, 0, 0);
        verify("wrap", w, 1, 0, 0);
        check_eq("wrap_b_err_count", ec_b, 0);
        check_eq("wrap_b_check_count", cc_b, 4);

        // err_count saturation on the narrow instance
        w.delete();
        for (int i = 0; i < 8; i++) w.push_back(8'h55);
        run_stream(w, 0, 0, 0);
        verify("sat", w, 0, 0, 0);
        check_eq("sat_b_err_count", ec_b, 3);

        // randomized streams with drops/corruptions, gaps and trickled writes
        for (int it = 0; it < 12; it++) begin
            gap  = $urandom_range(0, 3);
            trk  = ($urandom_range(0, 2) == 0);
            stop = trk ? 1'b0 : 1'($urandom_range(0, 1));
            n    = $urandom_range(4, 40);
            w.delete();
            cur = 8'h00;
            for (int j = 0; j < n; j++) begin
                r = $urandom_range(0, 9);
                if (r == 0) cur = cur + 8'd1;
                if (r == 1) w.push_back(8'($urandom_range(0, 255)));
                else w.push_back(cur);
                cur = cur + 8'd1;
            end
            run_stream(w, gap, stop, trk);
            verify($sformatf("rnd%0d", it), w, gap, stop, trk);
        end

        // enable dropped right after a read: in-flight word counted, no new read
        enable = 1'b0; rd_gap = 4'd3; stop_on_err = 1'b0; trickle = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        fifo_q = '{8'h00, 8'h01, 8'h02, 8'h03};
        rd_cyc.delete();
        empty  = 1'b0;
        enable = 1'b1;
        t = 0;
        while (rd_cyc.size() == 0 && t < 20) begin
            tick();
            t++;
        end
        check_eq("endrop_first_rd", rd_cyc.size(), 1);
        enable = 1'b0;
        check_eq("endrop_busy_inflight", busy, 1);
        repeat (10) tick();
        check_eq("endrop_rd_count", rd_cyc.size(), 1);
        check_eq("endrop_check_count", check_count, 1);
        check_eq("endrop_err_count", err_count, 0);
        check_eq("endrop_busy", busy, 0);

        // reset while a read is in flight: the word is never checked
        clear = 1'b1;
        tick();
        clear = 1'b0;
        fifo_q = '{8'h00, 8'h01, 8'h02};
        rd_cyc.delete();
        empty  = 1'b0;
        enable = 1'b1;
        t = 0;
        while (rd_cyc.size() == 0 && t < 20) begin
            tick();
            t++;
        end
        check_eq("rstmid_first_rd", rd_cyc.size(), 1);
        rst_n  = 1'b0;
        enable = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check_eq("rstmid_check_count", check_count, 0);
        check_eq("rstmid_err_count", err_count, 0);
        check_eq("rstmid_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
